posit_encoder_pipe: RTL
=======================

// Module: posit_encoder_pipe
// PURPOSE
//  Inverse of the posit data-extraction path: packs decoded fields (sign, regime value k,
//  exponent, fraction) into an N-bit posit with round-to-nearest-even and saturation.
//  Sits at the back end of the posit arithmetic datapath (after add/mul normalisation).
//  3-stage pipeline with valid/ready handshakes on both sides; full throughput, 1 result/cycle.
// PARAMETERS
//  N    8              posit width in bits
//  ES   3              exponent field width
//  MW   8              input fraction width (hidden 1 implied, not supplied)
//  RW   log2(N)+1      width of signed regime input (2's complement)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       input fields valid
//  in_ready     out  1       encoder can accept this cycle
//  in_zero      in   1       operand is zero (other fields ignored)
//  in_nar       in   1       operand is NaR (priority over in_zero)
//  in_sign      in   1       1 = negative
//  in_regime    in   RW      signed regime value k
//  in_exponent  in   ES      exponent field
//  in_fraction  in   MW      fraction bits after hidden 1, MSB first
//  out_valid    out  1       out_posit valid
//  out_ready    in   1       downstream accepts
//  out_posit    out  N       encoded posit
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low (rst_n); all stage valids,
//   out_valid and out_posit clear to 0 on reset; in_ready is 1 one cycle after release.
//  Handshake: transfer when valid&&ready on a cycle edge. out_valid/out_posit hold stable
//   while out_valid && !out_ready. Stage s advances when empty or the next stage advances;
//   in_ready = !v1 || stage-1 advances (combinational from out_ready). No bubbles, no drops, order kept.
//  Latency: exactly 3 cycles from input handshake to out_valid with out_ready held high.
//  S1: register fields; regime length rl = (k>=0) ? k+2 : 1-k; flags satmax = k>=N-2,
//   satmin = k<=-(N-1).
//  S2: body = regime bits (k>=0: k+1 ones then 0; k<0: -k zeros then 1) ++ exponent ++ fraction;
//   keep top N-1 bits, guard = next bit, sticky = OR of all remaining bits;
//   round up iff guard && (sticky || kept LSB). Carry ripples into exponent/regime naturally.
//  S3: special cases in priority: nar -> 1<<(N-1); zero -> 0; satmax -> maxpos {0,1..1};
//   satmin -> minpos {0..0,1}; rounded magnitude 0 -> minpos (never round to zero);
//   magnitude never reaches NaR (clamp to maxpos). If sign && !nar && !zero, output 2's complement
//   of {0,magnitude}.
//  Reset mid-operation: all in-flight results discarded, nothing emitted after release.
//  Simultaneous in_ready/out_ready stall release: pipeline shifts and accepts in same cycle.
// TESTING (N=8, ES=3, MW=8, out_ready=1 unless stated)
//  k=0,e=0,f=0,s=0 -> 8'h40 after 3 cycles; s=1 -> 8'hC0; k=1,e=0,f=0 -> 8'h60.
//  in_nar=1 -> 8'h80; in_zero=1 (any sign) -> 8'h00; nar+zero together -> 8'h80.
//  Saturation: k=6 -> 8'h7F; k=-7 -> 8'h01; k=-7,s=1 -> 8'hFF.
//  RNE, k=0,e=0: f=8'b0110_0000 -> 8'h42 (tie, odd); f=8'b0010_0000 -> 8'h40 (tie, even);
//   f=8'b0010_0001 -> 8'h41 (sticky).
//  Backpressure: out_ready=0, stream 5 inputs -> in_ready drops after 3 accepted, out_posit
//   stable; release -> all 5 results out in order, one per cycle, none lost.
//  rst_n asserted with 3 results in flight -> out_valid=0 immediately; no stale output after release.

Source files
------------

// File: rtl/posit_encoder_pipe.sv
// rtl/posit_encoder_pipe.sv - 3-stage posit field packer with RNE rounding and saturation
module posit_encoder_pipe #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int MW = 8,
    parameter int RW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_zero,
    input  logic          in_nar,
    input  logic          in_sign,
    input  logic [RW-1:0] in_regime,
    input  logic [ES-1:0] in_exponent,
    input  logic [MW-1:0] in_fraction,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_posit
);

    // Body is wide enough for the longest regime a RW-bit k can express (N+1 bits)
    // followed by the full exponent and fraction, so no input bit is ever shifted out.
    localparam int EF = ES + MW;
    localparam int BW = N + 1 + EF;

    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-2:0] MAXPOS = {(N-1){1'b1}};
    localparam logic [N-2:0] MINPOS = (N-1)'(1);

    // Pipeline occupancy and per-stage advance enables
    logic v1, v2, v3;
    logic load1, load2, load3;

    assign load3     = !v3 || out_ready;
    assign load2     = !v2 || load3;
    assign load1     = !v1 || load2;
    assign in_ready  = load1;
    assign out_valid = v3;

    // Stage 1 inputs: regime length and saturation flags derived from k
    logic          k_neg;
    logic [RW-1:0] rl_in;
    logic          satmax_in, satmin_in;

    assign k_neg     = in_regime[RW-1];
    assign rl_in     = k_neg ? (RW'(1) - in_regime) : (in_regime + RW'(2));
    assign satmax_in = !k_neg && (in_regime >= RW'(N - 2));
    assign satmin_in = k_neg && (in_regime <= RW'((1 << RW) - (N - 1)));

    // Stage 1 registers
    logic          s1_nar, s1_zero, s1_sign, s1_satmax, s1_satmin, s1_kneg;
    logic [RW-1:0] s1_rl;
    logic [ES-1:0] s1_exp;
    logic [MW-1:0] s1_frac;

    // Stage 1: capture decoded fields on an input handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1_nar    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_sign   <= 1'b0;
            s1_satmax <= 1'b0;
            s1_satmin <= 1'b0;
            s1_kneg   <= 1'b0;
            s1_rl     <= '0;
            s1_exp    <= '0;
            s1_frac   <= '0;
        end else if (load1) begin
            v1        <= in_valid;
            s1_nar    <= in_nar;
            s1_zero   <= in_zero;
            s1_sign   <= in_sign;
            s1_satmax <= satmax_in;
            s1_satmin <= satmin_in;
            s1_kneg   <= k_neg;
            s1_rl     <= rl_in;
            s1_exp    <= in_exponent;
            s1_frac   <= in_fraction;
        end
    end

    // Stage 2 datapath: assemble regime ++ exponent ++ fraction, then round to nearest even
    logic [RW-1:0] rl_m1;
    logic [BW-1:0] regime_bits, ef_bits, body;
    logic [N-2:0]  kept;
    logic          guard, sticky, round_up;
    logic [N-1:0]  mag_rnd;

    // Both regime forms have rl-1 repeated bits before the terminator, so one shift serves both
    always_comb begin
        rl_m1       = s1_rl - RW'(1);
        regime_bits = s1_kneg ? ({1'b1, {(BW-1){1'b0}}} >> rl_m1)
                              : ~({BW{1'b1}} >> rl_m1);
        ef_bits     = {{(BW-EF){1'b0}}, s1_exp, s1_frac} << (RW'(N + 1) - s1_rl);
        body        = regime_bits | ef_bits;
        kept        = body[BW-1 -: N-1];
        guard       = body[EF+1];
        sticky      = |body[EF:0];
        round_up    = guard && (sticky || kept[0]);
        mag_rnd     = {1'b0, kept} + N'(round_up);
    end

    // Stage 2 registers
    logic         s2_nar, s2_zero, s2_sign, s2_satmax, s2_satmin;
    logic [N-1:0] s2_mag;

    // Stage 2: hold the rounded magnitude (with carry bit) and special-case flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            s2_nar    <= 1'b0;
            s2_zero   <= 1'b0;
            s2_sign   <= 1'b0;
            s2_satmax <= 1'b0;
            s2_satmin <= 1'b0;
            s2_mag    <= '0;
        end else if (load2) begin
            v2        <= v1;
            s2_nar    <= s1_nar;
            s2_zero   <= s1_zero;
            s2_sign   <= s1_sign;
            s2_satmax <= s1_satmax;
            s2_satmin <= s1_satmin;
            s2_mag    <= mag_rnd;
        end
    end

    // Stage 3 datapath
    logic [N-2:0] mag;
    logic [N-1:0] posit_next;

    // Special cases in priority order; a rounded result never becomes zero or NaR
    always_comb begin
        mag = s2_mag[N-2:0];
        if (s2_satmax || s2_mag[N-1]) begin
            mag = MAXPOS;
        end else if (s2_satmin || (s2_mag == '0)) begin
            mag = MINPOS;
        end
        if (s2_nar) begin
            posit_next = NAR;
        end else if (s2_zero) begin
            posit_next = '0;
        end else if (s2_sign) begin
            posit_next = ~{1'b0, mag} + N'(1);
        end else begin
            posit_next = {1'b0, mag};
        end
    end

    // Stage 3: output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3        <= 1'b0;
            out_posit <= '0;
        end else if (load3) begin
            v3        <= v2;
            out_posit <= posit_next;
        end
    end

endmodule
